// File: rtl/rv32m_muldiv_if.sv
// Handshake/operand bundle between the execute stage and the RV32M unit.
interface rv32m_muldiv_if #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_dat;
  logic [XLEN-1:0] rs2_dat;
  logic [RD_W-1:0] rd_addr_in;
  logic            kill;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [RD_W-1:0] rd_addr_out;

  modport master (
    output start, funct3, rs1_dat, rs2_dat,
    output rd_addr_in, kill,
    input  busy, done, result, rd_addr_out
  );

  modport slave (
    input  start, funct3, rs1_dat, rs2_dat,
    input  rd_addr_in, kill,
    output busy, done, result, rd_addr_out
  );
endinterface

// File: rtl/rv32m_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add
// multiply and restoring divide, 32 iterations, one op in flight.
module rv32m_muldiv_unit #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  rv32m_muldiv_if.slave  io
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  localparam logic [XLEN-1:0] MIN_NEG =
    {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q;
  logic [4:0]      cnt_q;
  logic [2:0]      f3_q;
  logic            neg_q;
  logic [XLEN-1:0] m_q;
  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;
  logic [RD_W-1:0] rdp_q;
  logic [RD_W-1:0] rd_q;
  logic [XLEN-1:0] res_q;

  logic            a_sgn;
  logic            b_sgn;
  logic            sa;
  logic            sb;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            div0;
  logic            ovf;
  logic [XLEN-1:0] spec_res;
  logic            neg_d;

  logic [XLEN:0]     sum;
  logic [XLEN:0]     rem;
  logic              ge;
  logic [XLEN-1:0]   hi_d;
  logic [XLEN-1:0]   lo_d;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s;
  logic [XLEN-1:0]   rem_s;
  logic [XLEN-1:0]   res_fin;

  assign io.busy        = (state_q != IDLE);
  assign io.done        = (state_q == DONE);
  assign io.result      = res_q;
  assign io.rd_addr_out = rd_q;

  // Operand decode at accept
  always_comb begin
    a_sgn = io.funct3[2] ? !io.funct3[0]
                         : (io.funct3[1:0] != 2'b11);
    b_sgn = io.funct3[2] ? !io.funct3[0]
                         : !io.funct3[1];
    sa    = a_sgn & io.rs1_dat[XLEN-1];
    sb    = b_sgn & io.rs2_dat[XLEN-1];
    mag_a = sa ? (~io.rs1_dat + 1'b1) : io.rs1_dat;
    mag_b = sb ? (~io.rs2_dat + 1'b1) : io.rs2_dat;
    div0  = io.funct3[2] && (io.rs2_dat == '0);
    ovf   = io.funct3[2] && !io.funct3[0]
            && (io.rs1_dat == MIN_NEG)
            && (io.rs2_dat == '1);
    spec_res = '0;
    if (div0)
      spec_res = io.funct3[1] ? io.rs1_dat : '1;
    else if (ovf)
      spec_res = io.funct3[1] ? '0 : MIN_NEG;
    // Remainder takes the dividend sign only
    neg_d = (io.funct3[2] && io.funct3[1])
            ? sa : (sa ^ sb);
  end

  // One iteration of the shared datapath
  always_comb begin
    sum  = '0;
    rem  = '0;
    ge   = 1'b0;
    hi_d = hi_q;
    lo_d = lo_q;
    if (f3_q[2]) begin
      rem  = {hi_q, lo_q[XLEN-1]};
      ge   = (rem >= {1'b0, m_q});
      hi_d = ge ? (rem[XLEN-1:0] - m_q)
                : rem[XLEN-1:0];
      lo_d = {lo_q[XLEN-2:0], ge};
    end else begin
      sum  = {1'b0, hi_q}
             + (lo_q[0] ? {1'b0, m_q} : '0);
      hi_d = sum[XLEN:1];
      lo_d = {sum[0], lo_q[XLEN-1:1]};
    end
  end

  // Sign correction on the final iteration
  always_comb begin
    prod_s = neg_q ? (~{hi_d, lo_d} + 1'b1)
                   : {hi_d, lo_d};
    quo_s  = neg_q ? (~lo_d + 1'b1) : lo_d;
    rem_s  = neg_q ? (~hi_d + 1'b1) : hi_d;
    res_fin = '0;
    unique case (1'b1)
      (f3_q == 3'b000):
        res_fin = prod_s[XLEN-1:0];
      (!f3_q[2] && (f3_q != 3'b000)):
        res_fin = prod_s[2*XLEN-1:XLEN];
      (f3_q[2] && !f3_q[1]):
        res_fin = quo_s;
      (f3_q[2] && f3_q[1]):
        res_fin = rem_s;
      default:
        res_fin = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      f3_q    <= '0;
      neg_q   <= 1'b0;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      rdp_q   <= '0;
      rd_q    <= '0;
      res_q   <= '0;
    end else if (io.kill) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (io.start) begin
            f3_q  <= io.funct3;
            neg_q <= neg_d;
            rdp_q <= io.rd_addr_in;
            cnt_q <= '0;
            hi_q  <= '0;
            m_q   <= io.funct3[2] ? mag_b : mag_a;
            lo_q  <= io.funct3[2] ? mag_a : mag_b;
            if (div0 || ovf) begin
              res_q   <= spec_res;
              rd_q    <= io.rd_addr_in;
              state_q <= DONE;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            res_q   <= res_fin;
            rd_q    <= rdp_q;
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// Directed self-checking bench for rv32m_muldiv_unit.
module tb_rv32m_muldiv_unit;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;
  int   done_cnt;
  int   dc;

  rv32m_muldiv_if m ();

  rv32m_muldiv_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (m.done === 1'b1) done_cnt++;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Launch at the current negedge, wait for done,
  // return at the following negedge (unit idle).
  task automatic do_op(
    input string       tag,
    input logic [2:0]  f3,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [4:0]  rd,
    input logic [31:0] exp,
    input int          lat
  );
    int n;
    bit seen;
    m.start      = 1'b1;
    m.funct3     = f3;
    m.rs1_dat    = a;
    m.rs2_dat    = b;
    m.rd_addr_in = rd;
    @(negedge clk);
    m.start      = 1'b0;
    m.rs1_dat    = $urandom;
    m.rs2_dat    = $urandom;
    m.rd_addr_in = 5'($urandom);
    n    = 1;
    seen = 1'b0;
    while (n <= 60 && !seen) begin
      if (m.done === 1'b1) seen = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    check({tag, "_lat"}, 64'(n), 64'(lat));
    check({tag, "_res"}, 64'(m.result), 64'(exp));
    check({tag, "_rd"}, 64'(m.rd_addr_out), 64'(rd));
    check({tag, "_bsy"}, 64'(m.busy), 64'd1);
    @(negedge clk);
    check({tag, "_idle"}, 64'(m.busy), 64'd0);
  endtask

  initial begin
    n_chk        = 0;
    n_err        = 0;
    done_cnt     = 0;
    m.start      = 1'b0;
    m.kill       = 1'b0;
    m.funct3     = 3'd0;
    m.rs1_dat    = '0;
    m.rs2_dat    = '0;
    m.rd_addr_in = '0;
    rst_n        = 1'b1;
    #2 rst_n     = 1'b0;
    #1;
    check("rst_busy", 64'(m.busy), 64'd0);
    check("rst_done", 64'(m.done), 64'd0);
    check("rst_res", 64'(m.result), 64'd0);
    check("rst_rd", 64'(m.rd_addr_out), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op("mul", 3'b000, 32'd7, 32'hFFFF_FFFD,
          5'd5, 32'hFFFF_FFEB, 33);
    do_op("mulh", 3'b001, 32'h8000_0000,
          32'h8000_0000, 5'd6, 32'h4000_0000, 33);
    do_op("mulhu", 3'b011, 32'hFFFF_FFFF,
          32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, 33);
    do_op("mulhsu", 3'b010, 32'hFFFF_FFFF,
          32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFF, 33);
    do_op("divu0", 3'b101, 32'h1234, 32'd0,
          5'd9, 32'hFFFF_FFFF, 1);
    do_op("remu0", 3'b111, 32'h1234, 32'd0,
          5'd10, 32'h1234, 1);
    do_op("rem0", 3'b110, 32'hFFFF_FFFB, 32'd0,
          5'd11, 32'hFFFF_FFFB, 1);
    do_op("divovf", 3'b100, 32'h8000_0000,
          32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1);
    do_op("removf", 3'b110, 32'h8000_0000,
          32'hFFFF_FFFF, 5'd13, 32'h0, 1);
    do_op("div", 3'b100, 32'hFFFF_FFF9, 32'd2,
          5'd14, 32'hFFFF_FFFD, 33);
    do_op("rem", 3'b110, 32'hFFFF_FFF9, 32'd2,
          5'd15, 32'hFFFF_FFFF, 33);
    do_op("divu", 3'b101, 32'd100, 32'd7,
          5'd16, 32'd14, 33);
    do_op("remu", 3'b111, 32'd100, 32'd7,
          5'd17, 32'd2, 33);

    // Kill mid-CALC, with a stray start while busy
    m.start      = 1'b1;
    m.funct3     = 3'b000;
    m.rs1_dat    = 32'd3;
    m.rs2_dat    = 32'd5;
    m.rd_addr_in = 5'd20;
    @(negedge clk);
    m.start = 1'b0;
    repeat (3) @(negedge clk);
    m.start      = 1'b1;
    m.funct3     = 3'b101;
    m.rs2_dat    = 32'd0;
    m.rd_addr_in = 5'd21;
    @(negedge clk);
    m.start = 1'b0;
    repeat (5) @(negedge clk);
    dc     = done_cnt;
    m.kill = 1'b1;
    @(negedge clk);
    m.kill = 1'b0;
    check("kill_busy", 64'(m.busy), 64'd0);
    check("kill_done", 64'(m.done), 64'd0);
    check("kill_nodone", 64'(done_cnt), 64'(dc));
    check("kill_res", 64'(m.result), 64'd2);
    check("kill_rd", 64'(m.rd_addr_out), 64'd17);
    do_op("postkill", 3'b100, 32'd100, 32'hFFFF_FFF9,
          5'd22, 32'hFFFF_FFF2, 33);

    // Async reset mid-CALC
    m.start      = 1'b1;
    m.funct3     = 3'b011;
    m.rs1_dat    = 32'h10;
    m.rs2_dat    = 32'h20;
    m.rd_addr_in = 5'd23;
    @(negedge clk);
    m.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_busy", 64'(m.busy), 64'd0);
    check("mrst_done", 64'(m.done), 64'd0);
    check("mrst_res", 64'(m.result), 64'd0);
    check("mrst_rd", 64'(m.rd_addr_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dc    = done_cnt;
    repeat (40) @(negedge clk);
    check("mrst_nodone", 64'(done_cnt), 64'(dc));
    check("mrst_idle", 64'(m.busy), 64'd0);
    do_op("postrst", 3'b000, 32'h1_0001,
          32'h1_0001, 5'd31, 32'h0002_0001, 33);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
